// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes and the command-master FSM state encoding.
package axil_pkg;

  localparam logic [1:0] OKAY   = 2'd0;
  localparam logic [1:0] EXOKAY = 2'd1;
  localparam logic [1:0] SLVERR = 2'd2;
  localparam logic [1:0] DECERR = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WRITE   = 3'd1,
    ST_WRESP   = 3'd2,
    ST_RADDR   = 3'd3,
    ST_RDATA   = 3'd4,
    ST_RESPOND = 3'd5
  } axil_state_e;

endpackage

// File: rtl/axil_cmd_master_if.sv
// AXI4-Lite bus bundle between axil_cmd_master (master modport) and the interconnect (slave modport).
interface axil_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   M_AXI_AWADDR;
  logic [2:0]          M_AXI_AWPROT;
  logic                M_AXI_AWVALID;
  logic                M_AXI_AWREADY;
  logic [DATA_W-1:0]   M_AXI_WDATA;
  logic [DATA_W/8-1:0] M_AXI_WSTRB;
  logic                M_AXI_WVALID;
  logic                M_AXI_WREADY;
  logic [1:0]          M_AXI_BRESP;
  logic                M_AXI_BVALID;
  logic                M_AXI_BREADY;
  logic [ADDR_W-1:0]   M_AXI_ARADDR;
  logic [2:0]          M_AXI_ARPROT;
  logic                M_AXI_ARVALID;
  logic                M_AXI_ARREADY;
  logic [DATA_W-1:0]   M_AXI_RDATA;
  logic [1:0]          M_AXI_RRESP;
  logic                M_AXI_RVALID;
  logic                M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, input M_AXI_AWREADY,
    output M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, input M_AXI_WREADY,
    input  M_AXI_BRESP, M_AXI_BVALID, output M_AXI_BREADY,
    output M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, input M_AXI_ARREADY,
    input  M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, output M_AXI_RREADY
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, output M_AXI_AWREADY,
    input  M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID, output M_AXI_WREADY,
    output M_AXI_BRESP, M_AXI_BVALID, input M_AXI_BREADY,
    input  M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, output M_AXI_ARREADY,
    output M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID, input M_AXI_RREADY
  );
endinterface

// File: rtl/axil_watchdog.sv
// Transaction watchdog: counts busy cycles, flags expiry on the cycle the count reaches LIMIT.
module axil_watchdog #(
  parameter int unsigned LIMIT = 1024
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_active,
  output logic o_expire
);
  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_cnt;

  // Busy-cycle counter, saturating at LIMIT.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_active && (r_cnt != CW'(LIMIT))) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expire = i_active && (r_cnt == CW'(LIMIT - 1));
endmodule

// File: rtl/axil_cmd_master.sv
// Single-outstanding AXI4-Lite master driven by a valid/ready command port, answering on a response port.
// Define AXIL_CMD_MASTER_TIMEOUT_EN to add a watchdog that abandons a stalled transaction with SLVERR.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned M_AXI_ADDR_WIDTH = 32,
  parameter int unsigned M_AXI_DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT_CYCLES   = 1024
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_RESET,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_write,
  input  logic [M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [M_AXI_DATA_WIDTH-1:0] cmd_wdata,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [M_AXI_DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  axil_cmd_master_if.master           m_axi
);
  axil_state_e                 r_state;
  logic                        r_cmd_ready;
  logic                        r_awvalid, r_wvalid, r_bready, r_arvalid, r_rready;
  logic [M_AXI_ADDR_WIDTH-1:0] r_awaddr, r_araddr;
  logic [M_AXI_DATA_WIDTH-1:0] r_wdata;
  logic                        r_rsp_valid;
  logic [M_AXI_DATA_WIDTH-1:0] r_rsp_rdata;
  logic [1:0]                  r_rsp_resp;
  logic                        r_rsp_timeout;
  logic                        w_aw_done, w_w_done;
  logic                        w_expire;

  // A channel counts as done once its valid has already dropped or handshakes this cycle.
  assign w_aw_done = !r_awvalid || m_axi.M_AXI_AWREADY;
  assign w_w_done  = !r_wvalid  || m_axi.M_AXI_WREADY;

`ifdef AXIL_CMD_MASTER_TIMEOUT_EN
  logic w_busy;
  logic w_idle;

  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      ST_WRITE, ST_WRESP, ST_RADDR, ST_RDATA: w_busy = 1'b1;
      default:                                w_busy = 1'b0;
    endcase
  end

  assign w_idle = (r_state == ST_IDLE);

  axil_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .i_clk    (AXI_ACLK),
    .i_rst    (AXI_RESET),
    .i_clear  (w_idle),
    .i_active (w_busy),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  // Transaction FSM; the watchdog exit overrides any handshake in the same cycle.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_RESET) begin
      r_state       <= ST_IDLE;
      r_cmd_ready   <= 1'b1;
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_awaddr      <= '0;
      r_araddr      <= '0;
      r_wdata       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= OKAY;
      r_rsp_timeout <= 1'b0;
    end else if (w_expire) begin
      r_awvalid     <= 1'b0;
      r_wvalid      <= 1'b0;
      r_bready      <= 1'b0;
      r_arvalid     <= 1'b0;
      r_rready      <= 1'b0;
      r_rsp_valid   <= 1'b1;
      r_rsp_rdata   <= '0;
      r_rsp_resp    <= SLVERR;
      r_rsp_timeout <= 1'b1;
      r_state       <= ST_RESPOND;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid && r_cmd_ready) begin
            r_cmd_ready <= 1'b0;
            if (cmd_write) begin
              r_awaddr  <= cmd_addr;
              r_wdata   <= cmd_wdata;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= ST_WRITE;
            end else begin
              r_araddr  <= cmd_addr;
              r_arvalid <= 1'b1;
              r_state   <= ST_RADDR;
            end
          end
        end
        ST_WRITE: begin
          if (w_aw_done && w_w_done) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WRESP;
          end else begin
            if (m_axi.M_AXI_AWREADY) r_awvalid <= 1'b0;
            if (m_axi.M_AXI_WREADY)  r_wvalid  <= 1'b0;
          end
        end
        ST_WRESP: begin
          if (m_axi.M_AXI_BVALID) begin
            r_bready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= '0;
            r_rsp_resp    <= m_axi.M_AXI_BRESP;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESPOND;
          end
        end
        ST_RADDR: begin
          if (m_axi.M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (m_axi.M_AXI_RVALID) begin
            r_rready      <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_rsp_rdata   <= m_axi.M_AXI_RDATA;
            r_rsp_resp    <= m_axi.M_AXI_RRESP;
            r_rsp_timeout <= 1'b0;
            r_state       <= ST_RESPOND;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_rsp_valid <= 1'b0;
          r_cmd_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready           = r_cmd_ready;
  assign rsp_valid           = r_rsp_valid;
  assign rsp_rdata           = r_rsp_rdata;
  assign rsp_resp            = r_rsp_resp;
  assign rsp_timeout         = r_rsp_timeout;
  assign m_axi.M_AXI_AWADDR  = r_awaddr;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = r_awvalid;
  assign m_axi.M_AXI_WDATA   = r_wdata;
  assign m_axi.M_AXI_WSTRB   = {(M_AXI_DATA_WIDTH/8){1'b1}};
  assign m_axi.M_AXI_WVALID  = r_wvalid;
  assign m_axi.M_AXI_BREADY  = r_bready;
  assign m_axi.M_AXI_ARADDR  = r_araddr;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = r_arvalid;
  assign m_axi.M_AXI_RREADY  = r_rready;
endmodule

// File: doc/axil_cmd_master.md
# axil_cmd_master

AXI4-Lite master that turns single read/write commands from a simple valid/ready command port into AXI4-Lite transactions, then returns the data and response on a valid/ready response port. It sits between local control logic (bring-up sequencers, self-test) and the AXI4-Lite interconnect that hosts register slaves such as the revision block. There is one outstanding transaction at a time, with an optional watchdog timeout.

## Interface
- M_AXI_ADDR_WIDTH, 32: AXI address width.
- M_AXI_DATA_WIDTH, 32: AXI data width; WSTRB is all-ones.
- TIMEOUT_CYCLES, 1024: watchdog limit in clocks. Used only with AXIL_CMD_MASTER_TIMEOUT_EN.
- AXI_ACLK  in  1  sole clock.
- AXI_RESET  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  M_AXI_ADDR_WIDTH  byte address.
- cmd_wdata  in  M_AXI_DATA_WIDTH  write data.
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
- rsp_rdata  out  M_AXI_DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP/RRESP as received; SLVERR (2) on timeout.
- rsp_timeout  out  1  transaction abandoned by the watchdog.
- AW channel: M_AXI_AWADDR out ADDR_W, M_AXI_AWPROT out 3 (always 0), M_AXI_AWVALID out 1, M_AXI_AWREADY in 1.
- W channel: M_AXI_WDATA out DATA_W, M_AXI_WSTRB out DATA_W/8, M_AXI_WVALID out 1, M_AXI_WREADY in 1.
- B channel: M_AXI_BRESP in 2, M_AXI_BVALID in 1, M_AXI_BREADY out 1.
- AR channel: M_AXI_ARADDR out ADDR_W, M_AXI_ARPROT out 3 (always 0), M_AXI_ARVALID out 1, M_AXI_ARREADY in 1.
- R channel: M_AXI_RDATA in DATA_W, M_AXI_RRESP in 2, M_AXI_RVALID in 1, M_AXI_RREADY out 1.

## Operation
- States:
  - IDLE: cmd_ready=1.
  - WRITE: AW and W outstanding.
  - WRESP: BREADY=1.
  - RADDR: ARVALID=1.
  - RDATA: RREADY=1.
  - RESPOND: rsp_valid=1.
- IDLE, on cmd handshake:
  - Register the address and data.
  - For a write, assert AWVALID and WVALID together in the next cycle, then go to WRITE.
  - For a read, assert ARVALID in the next cycle, then go to RADDR.
- WRITE:
  - Each of AWVALID and WVALID drops independently on its own handshake.
  - When both have completed, go to WRESP. If both complete in the same cycle, go to WRESP directly.
  - Address and data stay stable while their valid is high.
- WRESP: on B handshake, capture BRESP, set rsp_rdata=0, go to RESPOND.
- RADDR: on AR handshake, go to RDATA.
- RDATA: on R handshake, capture RDATA and RRESP, go to RESPOND.
- RESPOND: on rsp handshake, go to IDLE. rsp_* outputs are held stable until the handshake.
- READY from the slave may already be high before VALID rises; the master never waits for READY before asserting VALID.
- Reset mid-transaction: all valid/ready outputs drop in the cycle after reset is sampled, and the FSM returns to IDLE. The interconnect must be reset alongside.

## Timing
- Reset values:
  - cmd_ready=1.
  - rsp_valid=0, rsp_rdata=0, rsp_resp=0, rsp_timeout=0.
  - All AXI VALID/READY outputs 0.
  - AWADDR/ARADDR/WDATA 0.
- Minimum latency with zero-wait slave, cmd handshake cycle = 0:
  - Read: ARVALID at 1, R accepted at 2, rsp_valid at 3.
  - Write: AW/W at 1, B at 2, rsp_valid at 3.
- cmd_ready stays 0 from the handshake until the return to IDLE, so back-to-back commands see a throughput of at most one per 4 clocks.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- AXIL_CMD_MASTER_TIMEOUT_EN defined:
  - A counter of ceil(log2(TIMEOUT_CYCLES+1)) bits clears on leaving IDLE and increments each cycle in WRITE, WRESP, RADDR or RDATA.
  - When it reaches TIMEOUT_CYCLES, all AXI valid/ready outputs are deasserted and the FSM goes to RESPOND with rsp_resp=2, rsp_timeout=1, rsp_rdata=0.
  - This is a recovery-only protocol exit.
- Undefined: no counter; the block waits indefinitely, and rsp_timeout is tied to 0.

## Structure
- Shared package axil_pkg holds:
  - Response constants OKAY=0, EXOKAY=1, SLVERR=2, DECERR=3.
  - The FSM state enum.
- Optional sub-module axil_watchdog (counter plus expiry flag), instantiated only under the macro.

## Test plan
- Zero-wait slave, read 0x10 returning 0x07E80429 -> rsp_rdata=0x07E80429, rsp_resp=0, rsp_valid at cycle 3.
- Write 0x4 / 0xDEADBEEF with AWREADY delayed 5 clocks and WREADY immediate -> WVALID drops after 1 cycle, AWVALID holds 5, single B, rsp_resp=0.
- Slave returns RRESP=2 on read of 0x1C -> rsp_resp=2, rsp_timeout=0.
- rsp_ready held low for 10 clocks -> rsp_* stable, cmd_ready=0 throughout; next command accepted only after the handshake.
- With macro and TIMEOUT_CYCLES=16, ARREADY never asserted -> ARVALID drops after 16 cycles, rsp_resp=2, rsp_timeout=1; without macro, ARVALID stays high.
- AXI_RESET asserted in WRESP -> all outputs at reset values the next cycle, cmd_ready=1, and a following read completes normally.
